up_adc_pn_scan: RTL and testbench

Register-bus sequencer for the JESD204 ADC core's per-channel PN monitors. On a start pulse it walks every channel through the same sequence: select a PN sequence, settle, clear sticky PN status, dwell, read status, restore control. It then reports a per-channel pass mask. It sits beside the processor side of the ADC core as a second `up_*` master, upstream of the bus mux.

---
 rtl/up_adc_pn_scan.sv | 229 ++++++++++++++++++++++
 tb/tb_up_adc_pn_scan.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_adc_pn_scan.sv
// Walks each ADC channel's PN monitor through select/settle/clear/dwell/read/restore
// over the up_* register bus and reports a per-channel pass mask.
//
// state     | meaning
// IDLE      | waiting for scan_start
// WR_SEL    | write request: PN select into CNTRL3
// W_SEL_ACK | wait for PN select write ack
// SETTLE    | PN generator/checker settle time
// WR_CLR    | write request: clear sticky pn_err/pn_oos
// W_CLR_ACK | wait for status clear write ack
// CHECK     | dwell while the monitor accumulates errors
// RD_STAT   | read request: channel status
// W_RD_ACK  | wait for status read data
// WR_RST    | write request: restore CNTRL3
// W_RST_ACK | wait for restore write ack
// NEXT      | advance channel or finish
// DONE      | one-cycle completion pulse
module up_adc_pn_scan #(
   parameter int          NUM_CHANNELS   = 1,
   parameter logic [13:0] CHAN_BASE      = 14'h0100,
   parameter logic [13:0] CHAN_STRIDE    = 14'h0010,
   parameter logic [13:0] CNTRL3_OFFSET  = 14'h0006,
   parameter logic [13:0] STATUS_OFFSET  = 14'h0001,
   parameter logic [3:0]  PN_SEL_CODE    = 4'h1,
   parameter logic [31:0] RESTORE_CNTRL3 = 32'h0,
   parameter int          SETTLE_CYCLES  = 1024,
   parameter int          CHECK_CYCLES   = 4096,
   parameter int          ACK_TIMEOUT    = 255
) (
   input  logic                    up_clk,
   input  logic                    up_rstn,
   input  logic                    scan_start,
   input  logic                    scan_abort,
   output logic                    scan_busy,
   output logic                    scan_done,
   output logic [NUM_CHANNELS-1:0] scan_pass,
   output logic                    scan_timeout,
   output logic                    up_wreq,
   output logic [13:0]             up_waddr,
   output logic [31:0]             up_wdata,
   input  logic                    up_wack,
   output logic                    up_rreq,
   output logic [13:0]             up_raddr,
   input  logic [31:0]             up_rdata,
   input  logic                    up_rack
);

   localparam int MAX_WAIT = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int CW       = $clog2(MAX_WAIT + 1);
   localparam int TW       = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, WR_SEL, W_SEL_ACK, SETTLE, WR_CLR, W_CLR_ACK, CHECK,
      RD_STAT, W_RD_ACK, WR_RST, W_RST_ACK, NEXT, DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              ch_q, ch_d;
   logic [CW-1:0]           wait_q, wait_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [NUM_CHANNELS-1:0] pass_q, pass_d;
   logic                    timeout_q, timeout_d;

   logic [13:0]             chan_addr;
   logic [NUM_CHANNELS-1:0] ch_bit;
   logic                    rd_fail;
   logic                    tmo_hit;

   assign chan_addr = CHAN_BASE + 14'(ch_q) * CHAN_STRIDE;
   assign ch_bit    = NUM_CHANNELS'(1) << ch_q;
   assign rd_fail   = |(up_rdata & 32'h0000_0006);
   // tmo_q counts cycles since the request; the flag lands ACK_TIMEOUT cycles after it
   assign tmo_hit   = (tmo_q >= TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         wait_q    <= '0;
         tmo_q     <= '0;
         pass_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         wait_q    <= wait_d;
         tmo_q     <= tmo_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      wait_d    = wait_q;
      tmo_d     = tmo_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      if ((state_q != IDLE) && scan_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (scan_start && !scan_abort) begin
                  pass_d    = '0;
                  timeout_d = 1'b0;
                  ch_d      = '0;
                  state_d   = WR_SEL;
               end
            end
            WR_SEL: begin
               tmo_d   = TW'(1);
               state_d = W_SEL_ACK;
            end
            W_SEL_ACK: begin
               if (up_wack) begin
                  wait_d  = CW'(SETTLE_CYCLES - 1);
                  state_d = SETTLE;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            SETTLE: begin
               if (wait_q == '0) state_d = WR_CLR;
               else              wait_d  = wait_q - CW'(1);
            end
            WR_CLR: begin
               tmo_d   = TW'(1);
               state_d = W_CLR_ACK;
            end
            W_CLR_ACK: begin
               if (up_wack) begin
                  wait_d  = CW'(CHECK_CYCLES - 1);
                  state_d = CHECK;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            CHECK: begin
               if (wait_q == '0) state_d = RD_STAT;
               else              wait_d  = wait_q - CW'(1);
            end
            RD_STAT: begin
               tmo_d   = TW'(1);
               state_d = W_RD_ACK;
            end
            W_RD_ACK: begin
               if (up_rack) begin
                  if (!rd_fail) pass_d = pass_q | ch_bit;
                  state_d = WR_RST;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            WR_RST: begin
               tmo_d   = TW'(1);
               state_d = W_RST_ACK;
            end
            W_RST_ACK: begin
               if (up_wack) begin
                  state_d = NEXT;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            NEXT: begin
               if (ch_q == 4'(NUM_CHANNELS - 1)) begin
                  state_d = DONE;
               end else begin
                  ch_d    = ch_q + 4'd1;
                  state_d = WR_SEL;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign scan_busy    = (state_q != IDLE);
   assign scan_done    = (state_q == DONE);
   assign scan_pass    = pass_q;
   assign scan_timeout = timeout_q;
   assign up_wreq      = (state_q == WR_SEL) || (state_q == WR_CLR) || (state_q == WR_RST);
   assign up_rreq      = (state_q == RD_STAT);

   // bus address/data are decoded from state so they hold from request to ack
   always_comb begin
      up_waddr = '0;
      up_wdata = '0;
      up_raddr = '0;
      case (state_q)
         WR_SEL, W_SEL_ACK: begin
            up_waddr = chan_addr + CNTRL3_OFFSET;
            up_wdata = {12'h0, PN_SEL_CODE, 16'h0};
         end
         WR_CLR, W_CLR_ACK: begin
            up_waddr = chan_addr + STATUS_OFFSET;
            up_wdata = 32'h0000_0006;
         end
         WR_RST, W_RST_ACK: begin
            up_waddr = chan_addr + CNTRL3_OFFSET;
            up_wdata = RESTORE_CNTRL3;
         end
         RD_STAT, W_RD_ACK: begin
            up_raddr = chan_addr + STATUS_OFFSET;
         end
         default: begin
            up_waddr = '0;
            up_wdata = '0;
            up_raddr = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_up_adc_pn_scan.sv
// Self-checking bench for up_adc_pn_scan: bus responder, transaction log and
// a reference model of the expected request stream, cycle timing and pass mask.
module tb_up_adc_pn_scan;
   localparam int NCH    = 2;
   localparam int SETTLE = 4;
   localparam int CHECK  = 8;
   localparam int TMO    = 16;

   logic            up_clk = 1'b0;
   logic            up_rstn = 1'b0;
   logic            scan_start = 1'b0;
   logic            scan_abort = 1'b0;
   logic            scan_busy, scan_done, scan_timeout;
   logic [NCH-1:0]  scan_pass;
   logic            up_wreq, up_rreq;
   logic [13:0]     up_waddr, up_raddr;
   logic [31:0]     up_wdata;
   logic            up_wack, up_rack;
   logic [31:0]     up_rdata;
   logic [95:0]     outs;

   up_adc_pn_scan #(
      .NUM_CHANNELS (NCH),
      .SETTLE_CYCLES(SETTLE),
      .CHECK_CYCLES (CHECK),
      .ACK_TIMEOUT  (TMO)
   ) dut (
      .up_clk      (up_clk),
      .up_rstn     (up_rstn),
      .scan_start  (scan_start),
      .scan_abort  (scan_abort),
      .scan_busy   (scan_busy),
      .scan_done   (scan_done),
      .scan_pass   (scan_pass),
      .scan_timeout(scan_timeout),
      .up_wreq     (up_wreq),
      .up_waddr    (up_waddr),
      .up_wdata    (up_wdata),
      .up_wack     (up_wack),
      .up_rreq     (up_rreq),
      .up_raddr    (up_raddr),
      .up_rdata    (up_rdata),
      .up_rack     (up_rack)
   );

   assign outs = {29'b0, scan_busy, scan_done, scan_pass, scan_timeout,
                  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr};

   always #5 up_clk = ~up_clk;

   int cyc = 0;
   always @(posedge up_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [13:0] addr;
      logic [31:0] data;
      int          cyc;
   } txn_t;

   txn_t        log_q[$];
   txn_t        exp_q[$];
   int          lat = 2;
   int          suppress_idx = -1;
   int          n_done = 0;
   logic [31:0] stat_by_ch [NCH];
   bit          pend = 1'b0;
   int          due = 0;
   txn_t        pend_t;

   // Bus responder: logs every request, acks it 'lat' cycles later unless suppressed.
   initial begin
      up_wack  = 1'b0;
      up_rack  = 1'b0;
      up_rdata = '0;
      forever begin
         @(negedge up_clk);
         up_wack  = 1'b0;
         up_rack  = 1'b0;
         up_rdata = '0;
         if (scan_done) n_done++;
         if (pend && cyc == due) begin
            pend = 1'b0;
            if (pend_t.wr) begin
               if (scan_busy) check("wr_hold", {up_waddr, up_wdata}, {pend_t.addr, pend_t.data});
               up_wack = 1'b1;
            end else begin
               int idx;
               if (scan_busy) check("rd_hold", up_raddr, pend_t.addr);
               idx = int'(14'((pend_t.addr - 14'h101) >> 4));
               if (idx >= NCH || idx < 0) idx = 0;
               up_rdata = stat_by_ch[idx];
               up_rack  = 1'b1;
            end
         end
         if (up_wreq || up_rreq) begin
            txn_t t;
            t.wr   = up_wreq;
            t.addr = up_wreq ? up_waddr : up_raddr;
            t.data = up_wreq ? up_wdata : 32'h0;
            t.cyc  = cyc;
            log_q.push_back(t);
            if (log_q.size() - 1 != suppress_idx) begin
               pend   = 1'b1;
               due    = cyc + lat;
               pend_t = t;
            end
         end
      end
   end

   function automatic int chan_len(input int l);
      return 4 * (l + 1) + SETTLE + CHECK + 1;
   endfunction

   function automatic logic pass_bit(input logic [31:0] s);
      return !(s[1] || s[2]);
   endfunction

   // Expected request stream of a full scan whose start was sampled at edge k.
   function automatic void build_model(input int k, input int l);
      exp_q.delete();
      for (int ch = 0; ch < NCH; ch++) begin
         int          s;
         logic [13:0] a;
         s = k + 1 + ch * chan_len(l);
         a = 14'h100 + 14'(ch * 16);
         exp_q.push_back('{1'b1, a + 14'h6, 32'h0001_0000, s});
         exp_q.push_back('{1'b1, a + 14'h1, 32'h6, s + l + 1 + SETTLE});
         exp_q.push_back('{1'b0, a + 14'h1, 32'h0, s + 2 * (l + 1) + SETTLE + CHECK});
         exp_q.push_back('{1'b1, a + 14'h6, 32'h0, s + 3 * (l + 1) + SETTLE + CHECK});
      end
   endfunction

   task automatic run_scan(input int l, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [NCH-1:0] exp_pass, input int poke);
      int k;
      int done_cyc;
      lat = l;
      stat_by_ch[0] = s0;
      stat_by_ch[1] = s1;
      log_q.delete();
      k = cyc;
      scan_start = 1'b1;
      @(negedge up_clk);
      scan_start = 1'b0;
      check("start_req", {scan_busy, up_wreq, scan_pass, scan_timeout}, {1'b1, 1'b1, {NCH{1'b0}}, 1'b0});
      build_model(k, l);
      done_cyc = -1;
      for (int i = 1; i < 2000 && done_cyc < 0; i++) begin
         if (scan_done) begin
            done_cyc = cyc;
         end else begin
            if (i == poke) scan_start = 1'b1;
            @(negedge up_clk);
            scan_start = 1'b0;
         end
      end
      check("done_cyc", done_cyc, k + 1 + NCH * chan_len(l));
      check("pass", scan_pass, exp_pass);
      check("timeout_clear", scan_timeout, 1'b0);
      check("n_txn", log_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < log_q.size())
            check("txn", {log_q[i].wr, log_q[i].addr, log_q[i].data, 32'(log_q[i].cyc)},
                         {exp_q[i].wr, exp_q[i].addr, exp_q[i].data, 32'(exp_q[i].cyc)});
      end
      @(negedge up_clk);
      check("done_one_cycle", {scan_busy, scan_done}, 2'b00);
   endtask

   typedef struct {
      int             l;
      logic [31:0]    s0;
      logic [31:0]    s1;
      logic [NCH-1:0] pass;
      int             poke;
   } vec_t;

   vec_t vec [5];

   initial begin
      int k, s1c, nd, r_cyc, t_cyc, d_cyc, n;
      bit found;
      vec[0] = '{2, 32'h0,         32'h0, 2'b11, 0};
      vec[1] = '{2, 32'h0,         32'h4, 2'b01, 0};
      vec[2] = '{3, 32'h2,         32'h0, 2'b10, 0};
      vec[3] = '{1, 32'h6,         32'h6, 2'b00, 30};
      vec[4] = '{4, 32'hFFFF_FFF9, 32'h1, 2'b11, 0};
      stat_by_ch[0] = '0;
      stat_by_ch[1] = '0;

      repeat (3) @(negedge up_clk);
      check("reset_outputs", outs, 96'h0);
      up_rstn = 1'b1;
      @(negedge up_clk);
      check("idle_after_reset", outs, 96'h0);

      for (int i = 0; i < 5; i++)
         run_scan(vec[i].l, vec[i].s0, vec[i].s1, vec[i].pass, vec[i].poke);

      for (int r = 0; r < 6; r++) begin
         logic [31:0] sv [2];
         int          l;
         for (int c = 0; c < 2; c++) begin
            case ($urandom_range(0, 4))
               0:       sv[c] = 32'h0;
               1:       sv[c] = 32'h2;
               2:       sv[c] = 32'h4;
               3:       sv[c] = 32'h6;
               default: sv[c] = $urandom;
            endcase
         end
         l = $urandom_range(1, 6);
         run_scan(l, sv[0], sv[1], {pass_bit(sv[1]), pass_bit(sv[0])}, $urandom_range(3, 60));
      end

      // ack timeout on channel 0 status-clear write
      lat = 2;
      stat_by_ch[0] = '0;
      stat_by_ch[1] = '0;
      log_q.delete();
      suppress_idx = 1;
      scan_start = 1'b1;
      @(negedge up_clk);
      scan_start = 1'b0;
      t_cyc = -1;
      d_cyc = -1;
      for (int i = 0; i < 200 && d_cyc < 0; i++) begin
         if (scan_timeout && t_cyc < 0) t_cyc = cyc;
         if (scan_done) d_cyc = cyc;
         else @(negedge up_clk);
      end
      r_cyc = (log_q.size() > 1) ? log_q[1].cyc : -1000;
      check("tmo_req_addr", (log_q.size() > 1) ? log_q[1].addr : 14'h0, 14'h101);
      check("tmo_flag_cyc", t_cyc, r_cyc + TMO);
      check("tmo_done_cyc", d_cyc, r_cyc + TMO);
      check("tmo_pass", scan_pass, 2'b00);
      repeat (20) @(negedge up_clk);
      check("tmo_no_more_req", log_q.size(), 2);
      check("tmo_sticky_idle", {scan_busy, scan_timeout}, 2'b01);
      suppress_idx = -1;

      // abort during channel 1 CHECK, restart three cycles later
      log_q.delete();
      k = cyc;
      scan_start = 1'b1;
      @(negedge up_clk);
      scan_start = 1'b0;
      s1c = k + 1 + chan_len(2);
      while (cyc < s1c + 13) @(negedge up_clk);
      nd = n_done;
      scan_abort = 1'b1;
      @(negedge up_clk);
      scan_abort = 1'b0;
      check("abort_busy", scan_busy, 1'b0);
      check("abort_pass_hold", scan_pass, 2'b01);
      @(negedge up_clk);
      @(negedge up_clk);
      check("abort_no_done", n_done, nd);
      run_scan(2, 32'h0, 32'h0, 2'b11, 0);

      // start and abort together in IDLE
      log_q.delete();
      scan_start = 1'b1;
      scan_abort = 1'b1;
      @(negedge up_clk);
      scan_start = 1'b0;
      scan_abort = 1'b0;
      repeat (5) @(negedge up_clk);
      check("sa_no_req", log_q.size(), 0);
      check("sa_idle", scan_busy, 1'b0);

      // async reset while waiting for read data
      lat = 10;
      log_q.delete();
      scan_start = 1'b1;
      @(negedge up_clk);
      scan_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (up_rreq) found = 1'b1;
         else @(negedge up_clk);
      end
      check("rst_saw_read", found, 1'b1);
      @(negedge up_clk);
      #2 up_rstn = 1'b0;
      #1 check("rst_async_outputs", outs, 96'h0);
      @(negedge up_clk);
      up_rstn = 1'b1;
      n = log_q.size();
      repeat (15) @(negedge up_clk);
      check("rst_idle_outputs", outs, 96'h0);
      check("rst_no_req", log_q.size(), n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
